// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM state encoding and effective-exponent helper for the fp alignment stage
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 24;
  localparam int GRS_W   = 3;
  localparam int ALIGN_W = 27;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
  // zero/subnormal operands use exponent 1 so their alignment matches normals
  function automatic logic [EXP_W-1:0] eexp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction
endpackage

// File: rtl/fp_sticky_shift.sv
// fp_sticky_shift: combinational right shift of a {mant,G,R,S} field, shifted-out bits ORed into bit0
//   val  in  27b value to shift
//   amt  in  shift amount 0..SHIFT_STEP
//   res  out shifted value with sticky in bit0
module fp_sticky_shift
  import fp_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic [ALIGN_W-1:0] val,
  input  logic [AMT_W-1:0]   amt,
  output logic [ALIGN_W-1:0] res
);
  logic [ALIGN_W-1:0] lost;
  assign lost = val & ~({ALIGN_W{1'b1}} << amt);
  assign res  = (val >> amt) | {{(ALIGN_W-1){1'b0}}, |lost};
endmodule

// File: rtl/fp_align32.sv
// fp_align32: fp adder operand alignment; orders operands and right-shifts the smaller mantissa SHIFT_STEP bits per cycle
//   clk, rst (async, active-high)
//   in_valid/in_ready        operand pair handshake (ready only in IDLE)
//   a_*/b_*                  unpacked operands: sign, biased exp, 24b mantissa with hidden bit
//   out_valid/out_ready      aligned pair handshake (valid in DONE, outputs held)
//   big_sign, small_sign, exp_out, mant_big, mant_small, swapped
//   FP_ALIGN_STICKY_EN: when defined G/R/S are tracked; otherwise low 3 bits are truncated to 0
module fp_align32
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int SHORTCUT   = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               a_sign,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [MANT_W-1:0]  a_mant,
  input  logic               b_sign,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [MANT_W-1:0]  b_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               big_sign,
  output logic               small_sign,
  output logic [EXP_W-1:0]   exp_out,
  output logic [ALIGN_W-1:0] mant_big,
  output logic [ALIGN_W-1:0] mant_small,
  output logic               swapped
);
  localparam int AMT_W = $clog2(SHIFT_STEP + 1);
  localparam logic [EXP_W-1:0] STEP_E = EXP_W'(SHIFT_STEP);
  localparam logic [EXP_W-1:0] SC_E   = EXP_W'(SHORTCUT);
`ifdef FP_ALIGN_STICKY_EN
  localparam logic [ALIGN_W-1:0] GRS_MASK = '1;
`else
  localparam logic [ALIGN_W-1:0] GRS_MASK = ~ALIGN_W'(7);
`endif
  state_t               state_q, state_d;
  logic                 big_sign_q, big_sign_d, small_sign_q, small_sign_d, swapped_q, swapped_d;
  logic [EXP_W-1:0]     exp_q, exp_d, rem_q, rem_d;
  logic [ALIGN_W-1:0]   mant_big_q, mant_big_d, mant_small_q, mant_small_d, shifted;
  logic [EXP_W-1:0]     ea, eb, diff;
  logic                 b_big;
  logic [MANT_W-1:0]    small_mant;
  logic [AMT_W-1:0]     k;
  assign ea         = eexp(a_exp);
  assign eb         = eexp(b_exp);
  assign b_big      = (eb > ea) || (eb == ea && b_mant > a_mant);
  assign diff       = b_big ? eb - ea : ea - eb;
  assign small_mant = b_big ? a_mant : b_mant;
  assign k          = AMT_W'(rem_q < STEP_E ? rem_q : STEP_E);
  fp_sticky_shift #(.AMT_W(AMT_W)) u_shift (
    .val(mant_small_q),
    .amt(k),
    .res(shifted)
  );
  always_comb begin
    state_d      = state_q;
    big_sign_d   = big_sign_q;
    small_sign_d = small_sign_q;
    swapped_d    = swapped_q;
    exp_d        = exp_q;
    rem_d        = rem_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    if (state_q == S_IDLE && in_valid) begin
      swapped_d    = b_big;
      big_sign_d   = b_big ? b_sign : a_sign;
      small_sign_d = b_big ? a_sign : b_sign;
      exp_d        = b_big ? eb : ea;
      mant_big_d   = {(b_big ? b_mant : a_mant), {GRS_W{1'b0}}};
      // far-apart operands only survive as sticky; skip the shift loop entirely
      mant_small_d = (diff >= SC_E ? {{(ALIGN_W-1){1'b0}}, |small_mant} : {small_mant, {GRS_W{1'b0}}}) & GRS_MASK;
      rem_d        = diff;
      state_d      = (diff == '0 || diff >= SC_E) ? S_DONE : S_SHIFT;
    end else if (state_q == S_SHIFT) begin
      mant_small_d = shifted & GRS_MASK;
      rem_d        = rem_q - EXP_W'(k);
      state_d      = rem_d == '0 ? S_DONE : S_SHIFT;
    end else if (state_q != S_DONE || out_ready) begin
      state_d      = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      swapped_q    <= 1'b0;
      exp_q        <= '0;
      rem_q        <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
    end else begin
      state_q      <= state_d;
      big_sign_q   <= big_sign_d;
      small_sign_q <= small_sign_d;
      swapped_q    <= swapped_d;
      exp_q        <= exp_d;
      rem_q        <= rem_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
    end
  end
  assign in_ready   = state_q == S_IDLE;
  assign out_valid  = state_q == S_DONE;
  assign big_sign   = big_sign_q;
  assign small_sign = small_sign_q;
  assign exp_out    = exp_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign swapped    = swapped_q;
endmodule

// File: tb/tb_fp_align32.sv
// tb_fp_align32: directed-vector self-checking bench for fp_align32 (SHIFT_STEP=4)
module tb_fp_align32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic [23:0] a_mant = '0, b_mant = '0;
  logic        in_ready, out_valid, big_sign, small_sign, swapped;
  logic [7:0]  exp_out;
  logic [26:0] mant_big, mant_small;
  int          n_cmp = 0, n_err = 0, lat;
`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  fp_align32 #(.SHIFT_STEP(4), .SHORTCUT(27)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_mant(a_mant),
    .b_sign(b_sign), .b_exp(b_exp), .b_mant(b_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .small_sign(small_sign), .exp_out(exp_out),
    .mant_big(mant_big), .mant_small(mant_small), .swapped(swapped)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic as, input logic [7:0] ae, input logic [23:0] am,
                    input logic bs, input logic [7:0] be, input logic [23:0] bm, output int l);
    @(negedge clk);
    {a_sign, a_exp, a_mant} = {as, ae, am};
    {b_sign, b_exp, b_mant} = {bs, be, bm};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
  endtask
  initial begin
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_small", {5'd0, mant_small}, 32'd0);
    check("rst_big", {5'd0, mant_big}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b0, 8'd127, 24'h800000, 1'b0, 8'd127, 24'h800000, lat);
    check("t1_lat", lat, 32'd1);
    check("t1_swap", {31'd0, swapped}, 32'd0);
    check("t1_exp", {24'd0, exp_out}, 32'd127);
    check("t1_small", {5'd0, mant_small}, 32'h4000000);
    check("t1_big", {5'd0, mant_big}, 32'h4000000);
    finish_op();
    op(1'b0, 8'd127, 24'h800000, 1'b0, 8'd128, 24'h800000, lat);
    check("t2_lat", lat, 32'd2);
    check("t2_swap", {31'd0, swapped}, 32'd1);
    check("t2_exp", {24'd0, exp_out}, 32'd128);
    check("t2_small", {5'd0, mant_small}, 32'h2000000);
    finish_op();
    op(1'b0, 8'd127, 24'h800001, 1'b1, 8'd137, 24'h800000, lat);
    check("t3_lat", lat, 32'd4);
    check("t3_bsign", {31'd0, big_sign}, 32'd1);
    check("t3_ssign", {31'd0, small_sign}, 32'd0);
    check("t3_exp", {24'd0, exp_out}, 32'd137);
    check("t3_small", {5'd0, mant_small}, STK ? 32'h0010001 : 32'h0010000);
    check("t3_big", {5'd0, mant_big}, 32'h4000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {a_exp, b_exp, in_valid} = {8'd10, 8'd20, 1'b1};
      @(posedge clk);
      #1;
      check("t6_valid", {31'd0, out_valid}, 32'd1);
      check("t6_ready", {31'd0, in_ready}, 32'd0);
      check("t6_small", {5'd0, mant_small}, STK ? 32'h0010001 : 32'h0010000);
      check("t6_exp", {24'd0, exp_out}, 32'd137);
    end
    in_valid = 1'b0;
    finish_op();
    op(1'b0, 8'd127, 24'hFFFFFF, 1'b0, 8'd97, 24'h800000, lat);
    check("t4_lat", lat, 32'd1);
    check("t4_swap", {31'd0, swapped}, 32'd0);
    check("t4_small", {5'd0, mant_small}, STK ? 32'd1 : 32'd0);
    finish_op();
    op(1'b0, 8'd0, 24'h000001, 1'b0, 8'd1, 24'h800000, lat);
    check("t5_lat", lat, 32'd1);
    check("t5_swap", {31'd0, swapped}, 32'd1);
    check("t5_exp", {24'd0, exp_out}, 32'd1);
    check("t5_small", {5'd0, mant_small}, 32'h0000008);
    finish_op();
    op(1'b0, 8'd127, 24'h800000, 1'b0, 8'd101, 24'h800000, lat);
    check("d26_lat", lat, 32'd8);
    check("d26_small", {5'd0, mant_small}, STK ? 32'd1 : 32'd0);
    finish_op();
    op(1'b0, 8'd127, 24'h800000, 1'b0, 8'd100, 24'h800000, lat);
    check("d27_lat", lat, 32'd1);
    check("d27_small", {5'd0, mant_small}, STK ? 32'd1 : 32'd0);
    finish_op();
    @(negedge clk);
    {a_sign, a_exp, a_mant} = {1'b0, 8'd127, 24'h800001};
    {b_sign, b_exp, b_mant} = {1'b1, 8'd137, 24'h800000};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t7_pre_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("t7_valid", {31'd0, out_valid}, 32'd0);
    check("t7_ready", {31'd0, in_ready}, 32'd1);
    check("t7_small", {5'd0, mant_small}, 32'd0);
    check("t7_exp", {24'd0, exp_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b0, 8'd127, 24'h800000, 1'b0, 8'd128, 24'h800000, lat);
    check("t7_after_lat", lat, 32'd2);
    check("t7_after_small", {5'd0, mant_small}, 32'h2000000);
    finish_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
